fetch_redirect_ctrl: RTL and testbench

//  Owns the fetch PC and picks each cycle's next fetch address. Sources in priority order:

---
 rtl/fetch_redirect_ctrl_if.sv | 29 ++
 rtl/fetch_redirect_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-redirect bundle between the fetch PC owner (master) and the
// branch/decode/predictor side of the pipeline (slave).
interface fetch_redirect_ctrl_if #(
    parameter int ADDR_LEN = 32
);
    logic                stall_if;
    logic                mispred_valid;
    logic [ADDR_LEN-1:0] mispred_pc;
    logic                jal_valid;
    logic [ADDR_LEN-1:0] jal_pc;
    logic                pred_taken;
    logic [ADDR_LEN-1:0] pred_pc;
    logic [ADDR_LEN-1:0] pc;
    logic                pc_valid;
    logic                kill_if;
    logic [1:0]          redirect_src;

    modport master (
        input  stall_if, mispred_valid, mispred_pc, jal_valid, jal_pc,
               pred_taken, pred_pc,
        output pc, pc_valid, kill_if, redirect_src
    );

    modport slave (
        output stall_if, mispred_valid, mispred_pc, jal_valid, jal_pc,
               pred_taken, pred_pc,
        input  pc, pc_valid, kill_if, redirect_src
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: prioritised next-PC selection, stall-time redirect capture
// with replay, and a kill window that squashes packets fetched before a redirect.
module fetch_redirect_ctrl #(
    parameter int                  ADDR_LEN     = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC     = '0,
    parameter int                  FETCH_STRIDE = 8,
    parameter int                  KILL_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_redirect_ctrl_if.master  bus
);
    localparam int                  KW        = $clog2(KILL_CYCLES + 1);
    localparam logic [KW-1:0]       KILL_LOAD = KW'(KILL_CYCLES);
    localparam logic [ADDR_LEN-1:0] STRIDE    = ADDR_LEN'(FETCH_STRIDE);

    localparam logic [1:0] SRC_SEQ  = 2'd0;
    localparam logic [1:0] SRC_PRED = 2'd1;
    localparam logic [1:0] SRC_JAL  = 2'd2;
    localparam logic [1:0] SRC_MISP = 2'd3;

    logic [ADDR_LEN-1:0] pc_reg, pc_next;
    logic                pc_valid_reg;
    logic [1:0]          src_reg, src_next;
    logic [KW-1:0]       kill_cnt_reg, kill_cnt_next;
    logic                pend_valid_reg, pend_valid_next;
    logic                pend_misp_reg, pend_misp_next;
    logic [ADDR_LEN-1:0] pend_pc_reg, pend_pc_next;
    logic                redirect;

    // The run/hold/kill modes are orthogonal: stall_if selects hold, while the
    // kill counter and pending latch together define the kill window.
    always_comb begin
        pc_next         = pc_reg;
        src_next        = src_reg;
        kill_cnt_next   = kill_cnt_reg;
        pend_valid_next = pend_valid_reg;
        pend_misp_next  = pend_misp_reg;
        pend_pc_next    = pend_pc_reg;
        redirect        = 1'b0;

        if (!bus.stall_if) begin
            // Any unstalled cycle consumes or supersedes the pending entry.
            pend_valid_next = 1'b0;
            if (bus.mispred_valid) begin
                pc_next  = bus.mispred_pc;
                src_next = SRC_MISP;
                redirect = 1'b1;
            end else if (pend_valid_reg && pend_misp_reg) begin
                pc_next  = pend_pc_reg;
                src_next = SRC_MISP;
                redirect = 1'b1;
            end else if (bus.jal_valid) begin
                pc_next  = bus.jal_pc;
                src_next = SRC_JAL;
                redirect = 1'b1;
            end else if (pend_valid_reg) begin
                pc_next  = pend_pc_reg;
                src_next = SRC_JAL;
                redirect = 1'b1;
            end else if (bus.pred_taken) begin
                pc_next  = bus.pred_pc;
                src_next = SRC_PRED;
            end else begin
                pc_next  = pc_reg + STRIDE;
                src_next = SRC_SEQ;
            end

            if (redirect) begin
                kill_cnt_next = KILL_LOAD;
            end else if (kill_cnt_reg != '0) begin
                kill_cnt_next = kill_cnt_reg - KW'(1);
            end
        end else begin
            // A jal may replace an older jal but never a pending mispredict.
            if (bus.mispred_valid) begin
                pend_valid_next = 1'b1;
                pend_misp_next  = 1'b1;
                pend_pc_next    = bus.mispred_pc;
            end else if (bus.jal_valid && !(pend_valid_reg && pend_misp_reg)) begin
                pend_valid_next = 1'b1;
                pend_misp_next  = 1'b0;
                pend_pc_next    = bus.jal_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            pc_valid_reg   <= 1'b0;
            src_reg        <= SRC_SEQ;
            kill_cnt_reg   <= '0;
            pend_valid_reg <= 1'b0;
            pend_misp_reg  <= 1'b0;
            pend_pc_reg    <= '0;
        end else begin
            pc_reg         <= pc_next;
            pc_valid_reg   <= 1'b1;
            src_reg        <= src_next;
            kill_cnt_reg   <= kill_cnt_next;
            pend_valid_reg <= pend_valid_next;
            pend_misp_reg  <= pend_misp_next;
            pend_pc_reg    <= pend_pc_next;
        end
    end

    assign bus.pc           = pc_reg;
    assign bus.pc_valid     = pc_valid_reg;
    assign bus.redirect_src = src_reg;
    assign bus.kill_if      = (kill_cnt_reg != '0) || pend_valid_reg;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed and randomized checks of fetch_redirect_ctrl against a queue-based
// reference model of the redirect priority, stall replay and kill rules.
module tb_fetch_redirect_ctrl;
    localparam int          KILL = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.ADDR_LEN(32)) bus ();

    fetch_redirect_ctrl #(
        .ADDR_LEN(32), .RESET_PC(RST_PC), .FETCH_STRIDE(8), .KILL_CYCLES(KILL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        misp;
        logic [31:0] addr;
    } pend_t;

    // Reference model state
    logic [31:0] m_pc;
    logic [1:0]  m_src;
    logic        m_valid;
    pend_t       m_q[$];
    int          m_since;
    bit          m_applied;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_kill();
        return (m_q.size() != 0) || (m_applied && m_since < KILL);
    endfunction

    // Evaluates the redirect rules on the inputs present at this clock edge.
    task automatic model_update();
        bit    have_misp, have_jal;
        pend_t best_misp, best_jal;
        if (reset) begin
            m_pc = RST_PC; m_valid = 1'b0; m_src = 2'd0;
            m_q.delete(); m_applied = 1'b0; m_since = 0;
            return;
        end
        m_valid = 1'b1;
        if (bus.stall_if) begin
            if (bus.mispred_valid)  m_q.push_back({1'b1, bus.mispred_pc});
            else if (bus.jal_valid) m_q.push_back({1'b0, bus.jal_pc});
            return;
        end
        have_misp = 0; have_jal = 0; best_misp = '0; best_jal = '0;
        foreach (m_q[i]) begin
            if (m_q[i].misp) begin have_misp = 1; best_misp = m_q[i]; end
            else begin have_jal = 1; best_jal = m_q[i]; end
        end
        m_q.delete();
        if (bus.mispred_valid)   begin m_pc = bus.mispred_pc; m_src = 2'd3; end
        else if (have_misp)      begin m_pc = best_misp.addr; m_src = 2'd3; end
        else if (bus.jal_valid)  begin m_pc = bus.jal_pc;     m_src = 2'd2; end
        else if (have_jal)       begin m_pc = best_jal.addr;  m_src = 2'd2; end
        else if (bus.pred_taken) begin m_pc = bus.pred_pc;    m_src = 2'd1; end
        else                     begin m_pc = m_pc + 32'd8;   m_src = 2'd0; end
        if (m_src >= 2'd2) begin m_since = 0; m_applied = 1'b1; end
        else m_since++;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        chk({tag, ".pc"},    bus.pc,                 m_pc);
        chk({tag, ".valid"}, 32'(bus.pc_valid),      32'(m_valid));
        chk({tag, ".kill"},  32'(bus.kill_if),       32'(m_kill()));
        chk({tag, ".src"},   32'(bus.redirect_src),  32'(m_src));
        $display("%0t %s pc=%h valid=%0d kill=%0d src=%0d", $time, tag,
                 bus.pc, bus.pc_valid, bus.kill_if, bus.redirect_src);
    endtask

    task automatic idle();
        bus.stall_if = 0; bus.mispred_valid = 0; bus.jal_valid = 0; bus.pred_taken = 0;
    endtask

    initial begin
        m_pc = RST_PC; m_src = 0; m_valid = 0; m_since = 0; m_applied = 0;
        bus.mispred_pc = '0; bus.jal_pc = '0; bus.pred_pc = '0;
        idle();

        // Reset held two cycles, then three free-running cycles
        step("rst0"); step("rst1");
        chk("rst.pc", bus.pc, 32'h0);
        chk("rst.kill", 32'(bus.kill_if), 32'd0);
        reset = 0;
        step("seq1"); chk("seq1.lit", bus.pc, 32'h8);
        step("seq2"); chk("seq2.lit", bus.pc, 32'h10);
        step("seq3"); chk("seq3.lit", bus.pc, 32'h18);

        // JAL from pc=0x10
        reset = 1; step("rstj"); reset = 0;
        step("j0"); step("j1"); chk("j.start", bus.pc, 32'h10);
        bus.jal_valid = 1; bus.jal_pc = 32'h34;
        step("jal"); chk("jal.lit", bus.pc, 32'h34); chk("jal.kill", 32'(bus.kill_if), 32'd1);
        idle();
        step("jal+1"); chk("jal+1.lit", bus.pc, 32'h3C); chk("jal+1.kill", 32'(bus.kill_if), 32'd1);
        step("jal+2"); chk("jal+2.kill", 32'(bus.kill_if), 32'd0);

        // All sources at once: mispredict wins
        bus.mispred_valid = 1; bus.mispred_pc = 32'h200;
        bus.jal_valid = 1; bus.jal_pc = 32'h34; bus.pred_taken = 1; bus.pred_pc = 32'h80;
        step("prio"); chk("prio.lit", bus.pc, 32'h200); chk("prio.src", 32'(bus.redirect_src), 32'd3);
        idle();

        // Stall capture at pc=0x40
        bus.jal_valid = 1; bus.jal_pc = 32'h40; step("to40"); idle();
        bus.stall_if = 1; bus.jal_valid = 1; bus.jal_pc = 32'h100; step("st1");
        bus.jal_valid = 0; bus.mispred_valid = 1; bus.mispred_pc = 32'h300; step("st2");
        bus.mispred_valid = 0; bus.pred_taken = 1; bus.pred_pc = 32'h500; step("st3");
        chk("st.hold", bus.pc, 32'h40); chk("st.kill", 32'(bus.kill_if), 32'd1);
        idle();
        step("rel"); chk("rel.lit", bus.pc, 32'h300);
        step("rel+1"); chk("rel+1.lit", bus.pc, 32'h308);

        // Wrap around the top of the address space
        bus.mispred_valid = 1; bus.mispred_pc = 32'hFFFF_FFF0; step("wr0"); idle();
        step("wr1"); chk("wr1.lit", bus.pc, 32'hFFFF_FFF8);
        step("wr2"); chk("wr2.lit", bus.pc, 32'h0);
        chk("wr2.kill", 32'(bus.kill_if), 32'd0); chk("wr2.src", 32'(bus.redirect_src), 32'd0);

        // Reset during kill window and pending capture
        bus.mispred_valid = 1; bus.mispred_pc = 32'h700; step("rk0");
        bus.mispred_valid = 0; bus.stall_if = 1; bus.jal_valid = 1; bus.jal_pc = 32'h900; step("rk1");
        reset = 1; step("rk2");
        chk("rk2.pc", bus.pc, RST_PC); chk("rk2.kill", 32'(bus.kill_if), 32'd0);
        reset = 0; idle();
        step("rk3"); chk("rk3.lit", bus.pc, 32'h8); chk("rk3.kill", 32'(bus.kill_if), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset             = ($urandom_range(99, 0) < 2);
            bus.stall_if      = ($urandom_range(99, 0) < 30);
            bus.mispred_valid = ($urandom_range(99, 0) < 10);
            bus.jal_valid     = ($urandom_range(99, 0) < 15);
            bus.pred_taken    = ($urandom_range(99, 0) < 30);
            bus.mispred_pc    = $urandom() & 32'hFFFF_FFFC;
            bus.jal_pc        = $urandom() & 32'hFFFF_FFFC;
            bus.pred_pc       = $urandom() & 32'hFFFF_FFFC;
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
